// File: rtl/dmem_bridge.sv
// Bridge from the CPU MEM-stage data port to a multi-cycle req/ack SRAM.
// One access in flight; the pipeline is held via stall_req until it completes.
module dmem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce,
    input  logic              cpu_wrn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wrdata,
    output logic [DATA_W-1:0] cpu_redata,
    output logic              stall_req,
    output logic              err,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ack,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_ce) begin
                    if (cpu_addr[1:0] == 2'b00) begin
                        we_d    = cpu_wrn;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wrdata;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end else begin
                        // Misaligned: skip the SRAM entirely and report in DONE.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (sram_ack) begin
                    rdata_d = we_q ? '0 : sram_rdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request and stall are decoded from state so they drop the edge after reset.
    assign sram_req   = (state_q == ACCESS);
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign stall_req  = ((state_q == IDLE) && cpu_ce) || (state_q == ACCESS);
    assign err        = (state_q == DONE) && err_q;
    assign cpu_redata = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized checks of dmem_bridge against a transaction-level model.
module tb_dmem_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_ce, cpu_wrn;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wrdata, cpu_redata;
    logic          stall_req, err, sram_req, sram_we, sram_ack;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce(cpu_ce), .cpu_wrn(cpu_wrn), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_redata(cpu_redata), .stall_req(stall_req), .err(err),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ack(sram_ack), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete CPU access. ack_at = ACCESS cycle index in which the SRAM acks;
    // values >= TO never ack, so the access must time out after TO ACCESS cycles.
    task automatic do_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input int ack_at, input logic [DW-1:0] rd, input logic chg);
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        int            k;
        int            stalls;
        bit            done;
        cpu_ce = 1'b1; cpu_wrn = wr; cpu_addr = a; cpu_wrdata = wd;
        #1;
        chk("stall_request_cycle", stall_req, 1);
        chk("req_request_cycle", sram_req, 0);
        stalls = 1;
        if (a[1:0] != 2'b00) begin
            tick();
            cpu_ce = 1'b0;
            exp_err = 1'b1;
            exp_rd  = '0;
        end else begin
            done = 0;
            k = 0;
            tick();
            while (!done) begin
                chk("access_req", sram_req, 1);
                chk("access_we", sram_we, wr);
                chk("access_addr", sram_addr, a);
                if (wr) chk("access_wdata", sram_wdata, wd);
                chk("access_stall", stall_req, 1);
                chk("access_err", err, 0);
                stalls++;
                if (chg) begin
                    cpu_addr   = $urandom & 32'hFFFF_FFFC;
                    cpu_wrdata = $urandom;
                    cpu_wrn    = 1'($urandom);
                    cpu_ce     = 1'($urandom);
                end
                if (k == ack_at) begin
                    sram_ack = 1'b1;
                    sram_rdata = rd;
                end
                tick();
                sram_ack = 1'b0;
                sram_rdata = $urandom;
                if (k == ack_at) begin
                    done = 1; exp_err = 1'b0; exp_rd = wr ? '0 : rd;
                end else if (k == TO - 1) begin
                    done = 1; exp_err = 1'b1; exp_rd = '0;
                end
                k++;
            end
            cpu_ce = 1'b0;
            chk("access_cycles", k, (ack_at < TO) ? ack_at + 1 : TO);
        end
        #1;
        chk("done_stall", stall_req, 0);
        chk("done_req", sram_req, 0);
        chk("done_err", err, exp_err);
        chk("done_redata", cpu_redata, exp_rd);
        chk("stall_total", stalls, (a[1:0] != 0) ? 1 : ((ack_at < TO) ? ack_at + 2 : TO + 1));
        tick();
        chk("idle_err", err, 0);
        chk("idle_stall", stall_req, 0);
        chk("idle_redata_held", cpu_redata, exp_rd);
    endtask

    initial begin
        rst = 1'b1; cpu_ce = 1'b0; cpu_wrn = 1'b0; cpu_addr = '0; cpu_wrdata = '0;
        sram_ack = 1'b0; sram_rdata = '0;
        tick(); tick();
        chk("rst_stall", stall_req, 0);
        chk("rst_req", sram_req, 0);
        chk("rst_err", err, 0);
        chk("rst_redata", cpu_redata, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_we", sram_we, 0);
        rst = 1'b0;
        tick();

        // Directed scenarios
        do_access(1'b0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, 1'b0);
        do_access(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 1'b0);
        do_access(1'b0, 32'h0000_0040, 32'h0, 99, 32'h0, 1'b0);

        // Late ack while idle must be ignored
        sram_ack = 1'b1; sram_rdata = 32'h5555_AAAA;
        tick();
        sram_ack = 1'b0;
        chk("late_ack_req", sram_req, 0);
        chk("late_ack_stall", stall_req, 0);
        chk("late_ack_err", err, 0);
        chk("late_ack_redata", cpu_redata, 0);

        // Reset during the second ACCESS cycle drops the access
        cpu_ce = 1'b1; cpu_wrn = 1'b0; cpu_addr = 32'h0000_0080;
        tick();
        chk("pre_rst_req", sram_req, 1);
        tick();
        chk("pre_rst_req2", sram_req, 1);
        rst = 1'b1; cpu_ce = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_req", sram_req, 0);
        chk("post_rst_stall", stall_req, 0);
        chk("post_rst_err", err, 0);
        tick();
        chk("post_rst_idle_req", sram_req, 0);
        chk("post_rst_idle_err", err, 0);

        // Two reads, CPU address disturbed mid-ACCESS
        do_access(1'b0, 32'h0000_0100, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
        do_access(1'b0, 32'h0000_0204, 32'h0, 1, 32'h7777_1111, 1'b0);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_access(1'($urandom), a, $urandom, int'($urandom_range(0, TO + 1)),
                      $urandom, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
